// File: rtl/operand_entry.sv
// operand_entry
//   Collects keypad keystrokes into a signed BCD entry, shows it live on an
//   8-nibble display word and, on ENTER, converts the BCD digits to a two's
//   complement operand one nibble per cycle.
// Ports
//   clock, reset        : posedge clock, synchronous active-high reset
//   key_valid, key_code : one-cycle key strobe; 0-9 digit, A neg, B bksp,
//                         C clear, D enter, E/F ignored
//   key_ready           : keys accepted (low while converting)
//   entry_full          : MAX_DIGITS digits held
//   display_word        : nibble 0 = LS digit, E = minus, F = blank
//   operand             : signed result of the last ENTER
//   operand_valid       : one-cycle pulse when operand updates
module operand_entry #(
   parameter int MAX_DIGITS = 6,
   parameter int WIDTH      = 21
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   output logic             key_ready,
   output logic             entry_full,
   output logic [31:0]      display_word,
   output logic [WIDTH-1:0] operand,
   output logic             operand_valid
);

   localparam int SW = 4 * MAX_DIGITS;
   localparam int CW = $clog2(MAX_DIGITS + 1);

   typedef enum logic [1:0] {S_ENTRY, S_CONVERT, S_DONE} state_t;

   state_t           r_state, w_state_nx;
   logic [SW-1:0]    r_store, w_store_nx;
   logic [CW-1:0]    r_count, w_count_nx;
   logic [CW-1:0]    r_idx, w_idx_nx;
   logic             r_sign, w_sign_nx;
   logic [WIDTH-1:0] r_acc, w_acc_nx, w_acc_step;
   logic [WIDTH-1:0] r_operand, w_operand_nx;
   logic             r_valid, w_valid_nx;
   logic             r_key_ready;
   logic [31:0]      r_display, w_disp;
   logic             r_full;

   // Display image of an entry: blank-filled, a lone 0 when empty, minus
   // sign just above the most significant shown digit.
   function automatic logic [31:0] f_fmt(input logic [SW-1:0] st,
                                         input logic [CW-1:0] cnt,
                                         input logic          sg);
      logic [31:0] w;
      w = '1;
      if (cnt == '0) w[3:0] = 4'h0;
      for (int i = 0; i < MAX_DIGITS; i++)
         if (i < int'(cnt)) w[i*4 +: 4] = st[i*4 +: 4];
      if (sg)
         for (int i = 1; i < 8; i++)
            if ((cnt == '0 && i == 1) || (int'(cnt) == i)) w[i*4 +: 4] = 4'hE;
      return w;
   endfunction

   // During conversion the store is shifted left so the top nibble is
   // always the next digit; the display register is frozen meanwhile.
   assign w_acc_step = (r_acc << 3) + (r_acc << 1) + WIDTH'(r_store[SW-1 -: 4]);

   always_comb begin
      w_state_nx   = r_state;
      w_store_nx   = r_store;
      w_count_nx   = r_count;
      w_sign_nx    = r_sign;
      w_idx_nx     = r_idx;
      w_acc_nx     = r_acc;
      w_operand_nx = r_operand;
      w_valid_nx   = 1'b0;
      case (r_state)
         S_ENTRY: begin
            if (key_valid) begin
               case (key_code)
                  4'hA: w_sign_nx = ~r_sign;
                  4'hB: begin
                     if (r_count != '0) begin
                        w_store_nx = {4'h0, r_store[SW-1:4]};
                        w_count_nx = r_count - CW'(1);
                     end
                  end
                  4'hC: begin
                     w_store_nx = '0;
                     w_count_nx = '0;
                     w_sign_nx  = 1'b0;
                  end
                  4'hD: begin
                     w_acc_nx   = '0;
                     w_idx_nx   = CW'(MAX_DIGITS - 1);
                     w_state_nx = S_CONVERT;
                  end
                  4'hE, 4'hF: ;
                  default: begin
                     // no leading zeros, no digits beyond capacity
                     if ((r_count != '0 || key_code != 4'h0) &&
                         r_count != CW'(MAX_DIGITS)) begin
                        w_store_nx = {r_store[SW-5:0], key_code};
                        w_count_nx = r_count + CW'(1);
                     end
                  end
               endcase
            end
         end
         S_CONVERT: begin
            w_acc_nx   = w_acc_step;
            w_store_nx = {r_store[SW-5:0], 4'h0};
            w_idx_nx   = r_idx - CW'(1);
            if (r_idx == '0) begin
               w_operand_nx = r_sign ? (~w_acc_step + WIDTH'(1)) : w_acc_step;
               w_valid_nx   = 1'b1;
               w_state_nx   = S_DONE;
            end
         end
         S_DONE: begin
            w_store_nx = '0;
            w_count_nx = '0;
            w_sign_nx  = 1'b0;
            w_state_nx = S_ENTRY;
         end
         default: w_state_nx = S_ENTRY;
      endcase
   end

   assign w_disp = f_fmt(w_store_nx, w_count_nx, w_sign_nx);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_ENTRY;
         r_store     <= '0;
         r_count     <= '0;
         r_sign      <= 1'b0;
         r_idx       <= '0;
         r_acc       <= '0;
         r_operand   <= '0;
         r_valid     <= 1'b0;
         r_key_ready <= 1'b1;
         r_display   <= 32'hFFFF_FFF0;
         r_full      <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_store     <= w_store_nx;
         r_count     <= w_count_nx;
         r_sign      <= w_sign_nx;
         r_idx       <= w_idx_nx;
         r_acc       <= w_acc_nx;
         r_operand   <= w_operand_nx;
         r_valid     <= w_valid_nx;
         r_key_ready <= (w_state_nx == S_ENTRY);
         if (r_state != S_CONVERT) begin
            r_display <= w_disp;
            r_full    <= (w_count_nx == CW'(MAX_DIGITS));
         end
      end
   end

   assign key_ready     = r_key_ready;
   assign entry_full    = r_full;
   assign display_word  = r_display;
   assign operand       = r_operand;
   assign operand_valid = r_valid;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: keys driven on the falling edge, outputs sampled on
// the falling edge; expected operands queued at ENTER and checked on the pulse.
module tb_operand_entry;

   localparam int MD = 6;
   localparam int W  = 21;

   logic          clk = 1'b0;
   logic          reset, key_valid;
   logic [3:0]    key_code;
   logic          key_ready, entry_full, operand_valid;
   logic [31:0]   display_word;
   logic [W-1:0]  operand;

   int            n_vec = 0;
   int            n_err = 0;
   logic [31:0]   sb_q[$];

   operand_entry #(.MAX_DIGITS(MD), .WIDTH(W)) dut (
      .clock(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
      .key_ready(key_ready), .entry_full(entry_full), .display_word(display_word),
      .operand(operand), .operand_valid(operand_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic press(input logic [3:0] c);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'h0;
   endtask

   // ENTER, then check key_ready low and the exact valid cycle; optionally
   // push a digit key into the conversion window to confirm it is dropped.
   task automatic enter_chk(input logic [31:0] exp, input bit inject);
      sb_q.push_back(exp);
      press(4'hD);
      for (int n = 0; n <= MD; n++) begin
         if (n > 0) @(negedge clk);
         key_valid = 1'b0;
         chk("krdy_conv", 32'(key_ready), 32'd0);
         chk("ovld_lat", 32'(operand_valid), (n == MD) ? 32'd1 : 32'd0);
         if (inject && n == 0) begin
            key_valid = 1'b1;
            key_code  = 4'h3;
         end
      end
      @(negedge clk);
      chk("krdy_after", 32'(key_ready), 32'd1);
      chk("disp_after", display_word, 32'hFFFF_FFF0);
      chk("ovld_drop", 32'(operand_valid), 32'd0);
   endtask

   // Scoreboard side: every valid pulse must match the oldest queued operand.
   always @(negedge clk) begin
      if (operand_valid) begin
         if (sb_q.size() == 0) chk("ovld_unexp", 32'd1, 32'd0);
         else chk("operand", 32'(operand), sb_q.pop_front());
      end
   end

   initial begin
      reset = 1'b1; key_valid = 1'b0; key_code = 4'h0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_disp", display_word, 32'hFFFF_FFF0);
      chk("rst_krdy", 32'(key_ready), 32'd1);
      chk("rst_full", 32'(entry_full), 32'd0);
      chk("rst_op", 32'(operand), 32'd0);
      chk("rst_ovld", 32'(operand_valid), 32'd0);

      press(4'h1); chk("d1", display_word, 32'hFFFF_FFF1);
      press(4'h2); press(4'h3); chk("d123", display_word, 32'hFFFF_F123);
      enter_chk(32'h0000_007B, 1'b0);

      press(4'h4); press(4'h5); press(4'hA);
      chk("dm45", display_word, 32'hFFFF_FE45);
      enter_chk(32'h001F_FFD3, 1'b0);

      press(4'h0); chk("lead0", display_word, 32'hFFFF_FFF0);
      press(4'h0); press(4'h5); chk("d005", display_word, 32'hFFFF_FFF5);
      press(4'hE); press(4'hF); chk("ef_ign", display_word, 32'hFFFF_FFF5);
      press(4'hC); chk("clr", display_word, 32'hFFFF_FFF0);
      press(4'h9); press(4'h8); chk("d98", display_word, 32'hFFFF_FF98);
      press(4'hB); chk("bksp", display_word, 32'hFFFF_FFF9);
      press(4'hB); chk("bksp0", display_word, 32'hFFFF_FFF0);
      press(4'hB); chk("bksp_empty", display_word, 32'hFFFF_FFF0);

      press(4'hA); chk("neg_empty", display_word, 32'hFFFF_FFE0);
      press(4'h7); chk("neg7", display_word, 32'hFFFF_FFE7);
      press(4'hA); chk("unneg7", display_word, 32'hFFFF_FFF7);
      press(4'hA); press(4'hB); chk("bksp_sign", display_word, 32'hFFFF_FFE0);
      press(4'hC); chk("clr_sign", display_word, 32'hFFFF_FFF0);

      for (int d = 1; d <= MD; d++) press(4'(d));
      chk("d123456", display_word, 32'hFF12_3456);
      chk("full", 32'(entry_full), 32'd1);
      press(4'h7); chk("ovf_ign", display_word, 32'hFF12_3456);
      chk("full_hold", 32'(entry_full), 32'd1);
      enter_chk(32'h0001_E240, 1'b0);
      chk("full_clr", 32'(entry_full), 32'd0);

      press(4'hA); enter_chk(32'h0000_0000, 1'b0);

      press(4'hA);
      for (int d = 0; d < MD; d++) press(4'h9);
      chk("dm999999", display_word, 32'hFE99_9999);
      enter_chk(32'h0010_BDC1, 1'b0);

      press(4'h8); enter_chk(32'h0000_0008, 1'b1);
      chk("inj_drop", display_word, 32'hFFFF_FFF0);

      // reset mid-conversion: no pulse, everything back to reset values
      press(4'h2); press(4'hD);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mrst_op", 32'(operand), 32'd0);
      chk("mrst_ovld", 32'(operand_valid), 32'd0);
      chk("mrst_disp", display_word, 32'hFFFF_FFF0);
      chk("mrst_krdy", 32'(key_ready), 32'd1);
      repeat (12) @(negedge clk);
      chk("mrst_quiet", 32'(operand), 32'd0);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
